// File: rtl/aes_result_unpacker.sv
// -----------------------------------------------------------------------------
// aes_result_unpacker
//
// Captures 128-bit result blocks from a one-cycle strobe into a DEPTH-entry
// block FIFO and hands each block back as four 32-bit words over a
// valid/ready interface. word0 = bits[127:96] ... word3 = bits[31:0], which
// matches the upstream packing order.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   reset       in   asynchronous active-low reset (control state only)
//   flush       in   synchronous clear of pointers/count/overflow
//   blockIn     in   128-bit block, sampled when blockValid=1
//   blockValid  in   one-cycle write strobe, one block per high cycle
//   wordOut     out  head word, valid when wordValid=1
//   wordValid   out  FIFO holds at least one block
//   wordReady   in   consumer takes wordOut when wordValid=1
//   blkCount    out  number of stored blocks, 0..DEPTH
//   full        out  blkCount == DEPTH
//   overflow    out  a strobed block was dropped
//
// Configuration macro:
//   OVERFLOW_STICKY_EN  defined   -> overflow stays set until flush/reset
//                       undefined -> overflow is a one-cycle pulse per drop
// -----------------------------------------------------------------------------
module aes_result_unpacker #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [127:0]  blockIn,
    input  logic          blockValid,
    output logic [31:0]   wordOut,
    output logic          wordValid,
    input  logic          wordReady,
    output logic [AW:0]   blkCount,
    output logic          full,
    output logic          overflow
);

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    word_idx_q, word_idx_d;
    logic [AW:0]   blk_count_q, blk_count_d;
    logic          overflow_q, overflow_d;

    logic          full_s;
    logic          not_empty_s;
    logic          pop_word_s;
    logic          pop_blk_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [127:0]  head_blk_s;

    assign full_s      = (blk_count_q == DEPTH_C);
    assign not_empty_s = (blk_count_q != {(AW+1){1'b0}});

    // Handshake decode; a last-word pop frees a slot in the same cycle so a
    // strobe arriving on a full FIFO can still be taken.
    always_comb begin
        pop_word_s = not_empty_s && wordReady && !flush;
        pop_blk_s  = pop_word_s && (word_idx_q == 2'd3);
        wr_en_s    = blockValid && !flush && (!full_s || pop_blk_s);
        drop_s     = blockValid && !flush && full_s && !pop_blk_s;
    end

    // Next-state for pointers, word index, block count and overflow flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        word_idx_d  = word_idx_q;
        blk_count_d = blk_count_q;
        overflow_d  = overflow_q;
        if (flush) begin
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            word_idx_d  = 2'd0;
            blk_count_d = {(AW+1){1'b0}};
            overflow_d  = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_word_s) begin
                word_idx_d = word_idx_q + 2'd1;
            end else begin
                word_idx_d = word_idx_q;
            end
            if (pop_blk_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, pop_blk_s})
                2'b10:   blk_count_d = blk_count_q + CNT_ONE;
                2'b01:   blk_count_d = blk_count_q - CNT_ONE;
                default: blk_count_d = blk_count_q;
            endcase
`ifdef OVERFLOW_STICKY_EN
            overflow_d = overflow_q | drop_s;
`else
            overflow_d = drop_s;
`endif
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            word_idx_q  <= 2'd0;
            blk_count_q <= {(AW+1){1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            word_idx_q  <= word_idx_d;
            blk_count_q <= blk_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Block storage; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= blockIn;
        end
    end

    // Head word select, most significant word first.
    always_comb begin
        head_blk_s = mem_q[rd_ptr_q];
        case (word_idx_q)
            2'd0:    wordOut = head_blk_s[127:96];
            2'd1:    wordOut = head_blk_s[95:64];
            2'd2:    wordOut = head_blk_s[63:32];
            2'd3:    wordOut = head_blk_s[31:0];
            default: wordOut = 32'h0000_0000;
        endcase
    end

    assign wordValid = not_empty_s;
    assign blkCount  = blk_count_q;
    assign full      = full_s;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_aes_result_unpacker.sv
// -----------------------------------------------------------------------------
// tb_aes_result_unpacker
//
// Scoreboard bench. The driver keeps a queue of expected words (four per
// accepted block) and decides acceptance/drop from the queue contents; a
// separate monitor compares the DUT status and every accepted word against it.
// -----------------------------------------------------------------------------
module tb_aes_result_unpacker;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [127:0]  blockIn;
    logic          blockValid;
    logic [31:0]   wordOut;
    logic          wordValid;
    logic          wordReady;
    logic [AW:0]   blkCount;
    logic          full;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        ovf_exp = 1'b0;

    aes_result_unpacker #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .blockIn    (blockIn),
        .blockValid (blockValid),
        .wordOut    (wordOut),
        .wordValid  (wordValid),
        .wordReady  (wordReady),
        .blkCount   (blkCount),
        .full       (full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: 3 time units after each negedge, status must match the model;
    // an accepted word must equal the head of the expected-word queue.
    always begin
        int          sz;
        int          blocks;
        logic [31:0] w;
        @(negedge clk);
        #3;
        sz     = exp_q.size();
        blocks = (sz + 3) / 4;
        checks++;
        if (wordValid !== (sz > 0)) begin
            errors++;
            $display("FAIL wordValid: got %b expected %b", wordValid, (sz > 0));
        end
        checks++;
        if (int'(blkCount) != blocks || $isunknown(blkCount)) begin
            errors++;
            $display("FAIL blkCount: got %0d expected %0d", blkCount, blocks);
        end
        checks++;
        if (full !== (blocks == DEPTH)) begin
            errors++;
            $display("FAIL full: got %b expected %b", full, (blocks == DEPTH));
        end
        checks++;
        if (overflow !== ovf_exp) begin
            errors++;
            $display("FAIL overflow: got %b expected %b", overflow, ovf_exp);
        end
        if (reset && !flush && wordReady && sz > 0) begin
            w = exp_q.pop_front();
            checks++;
            if (wordOut !== w) begin
                errors++;
                $display("FAIL word: got %h expected %h", wordOut, w);
            end
        end
    end

    // One clock cycle of stimulus; the model decides what the DUT must do with it.
    task automatic cyc(input logic bv, input logic [127:0] bi, input logic rdy, input logic fl);
        int   sz;
        logic pop_blk;
        logic accept;
        logic drop;
        @(negedge clk);
        blockValid = bv;
        blockIn    = bi;
        wordReady  = rdy;
        flush      = fl;
        sz      = exp_q.size();
        pop_blk = rdy && (sz % 4 == 1);
        accept  = bv && !fl && (((sz + 3) / 4) < DEPTH || pop_blk);
        drop    = bv && !fl && !accept;
        #4;
        if (fl) begin
            exp_q.delete();
            ovf_exp = 1'b0;
        end else begin
            if (accept) begin
                exp_q.push_back(bi[127:96]);
                exp_q.push_back(bi[95:64]);
                exp_q.push_back(bi[63:32]);
                exp_q.push_back(bi[31:0]);
            end
`ifdef OVERFLOW_STICKY_EN
            ovf_exp = ovf_exp | drop;
`else
            ovf_exp = drop;
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        blockValid = 1'b0;
        wordReady  = 1'b0;
        flush      = 1'b0;
        exp_q.delete();
        ovf_exp    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cyc(1'b0, 128'h0, 1'b1, 1'b0);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: words left %0d expected 0", exp_q.size());
        end
        cyc(1'b0, 128'h0, 1'b0, 1'b0);
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) cyc(1'b1, rnd128(), 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        blockIn    = 128'h0;
        blockValid = 1'b0;
        wordReady  = 1'b0;
        do_reset();

        // Single block, word order
        cyc(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b0);
        drain();

        // Fill, drop a 5th strobe, then drain in order
        fill4();
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 128'h0, 1'b0, 1'b0);
        drain();

        // 5th strobe coincides with the final word pop of the head block
        fill4();
        repeat (3) cyc(1'b0, 128'h0, 1'b1, 1'b0);
        cyc(1'b1, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b1, 1'b0);
        drain();

        // wordReady toggling over one block
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 128'h0, (i % 2 == 0), 1'b0);
        drain();

        // Flush after word 1 of block 2, then a fresh block
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 128'h0, 1'b1, 1'b0);
        cyc(1'b0, 128'h0, 1'b0, 1'b1);
        cyc(1'b1, rnd128(), 1'b1, 1'b0);
        drain();

        // Reset after word 1 of block 2, then a fresh block
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 128'h0, 1'b1, 1'b0);
        do_reset();
        cyc(1'b1, rnd128(), 1'b1, 1'b0);
        drain();

        // Two drops, idle, then flush clears everything
        fill4();
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        cyc(1'b1, rnd128(), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 128'h0, 1'b0, 1'b0);
        cyc(1'b1, rnd128(), 1'b0, 1'b1);
        cyc(1'b0, 128'h0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 3) == 0, rnd128(), ($urandom % 4) != 0, ($urandom % 64) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
